control_adquisicion_lockin: RTL and testbench
=============================================

# control_adquisicion_lockin

Run sequencer for the segmented lock-in datapath (multiplier plus phase/quadrature moving-average filters). It performs the following steps:
- latches a measurement configuration;
- clears the datapath with a synchronous reset pulse;
- enables it and waits for the filters to become ready;
- pairs each phase result with its matching quadrature result into one record;
- repeats for a programmed number of measurements, with timeout and abort.

It sits between the HPS/register-bank control interface and the lock-in core.

## Interface
Parameters:
- CLEAR_CYCLES, 4, cycles `lockin_reset_n` is held low in CLEAR (≥1).
- CNT_W, 16, width of measurement counter and `result_index`.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; ignored unless IDLE.
- abort  in  1  level; forces IDLE from any state.
- cfg_ptos_x_ciclo  in  16  points per cycle for the next run.
- cfg_frames_integracion  in  16  integration frames for the next run.
- cfg_n_mediciones  in  CNT_W  measurements per run; 0 is treated as 1.
- cfg_timeout  in  32  max cycles in ARM or waiting for a pair; 0 = disabled.
- lockin_reset_n  out  1  synchronous reset to core, active-low.
- lockin_enable  out  1  core enable.
- ptos_x_ciclo, frames_integracion  out  16 each  configuration latched at start.
- lockin_ready  in  1  core filters ready.
- fase_in / fase_in_valid  in  64 / 1  core phase output.
- cuad_in / cuad_in_valid  in  64 / 1  core quadrature output.
- result_fase, result_cuad  out  64 each  paired record.
- result_valid  out  1  one-cycle strobe per record.
- result_index  out  CNT_W  0-based record number.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at normal completion.
- error_timeout, error_overrun  out  1 each  sticky; cleared by the next accepted `start`.
- state  out  3  encoded FSM state: IDLE=0, CLEAR=1, ARM=2, RUN=3, EMIT=4, DONE=5.

## Operation
- **IDLE**
  - `lockin_enable`=0, `lockin_reset_n`=1.
  - On `start`: latch the three cfg values, latch `n`=max(`cfg_n_mediciones`,1), clear the count, clear the error flags, go to CLEAR.
- **CLEAR**
  - `lockin_reset_n`=0 for exactly CLEAR_CYCLES cycles, then go to ARM.
  - Configuration outputs are already stable during CLEAR.
- **ARM**
  - `lockin_enable`=1.
  - On `lockin_ready`=1, go to RUN.
  - If the timer reaches `cfg_timeout`: set `error_timeout`, go to IDLE.
- **RUN**
  - `lockin_enable`=1.
  - Each `fase_in_valid` captures `fase_in` and sets `have_f`; each `cuad_in_valid` captures `cuad_in` and sets `have_c`. Both may arrive in the same cycle or in either order.
  - A valid on a side whose flag is already set overwrites the captured value and sets `error_overrun`; the run continues.
  - When both flags are set, go to EMIT.
  - On timeout, set `error_timeout` and go to IDLE.
- **EMIT**
  - `result_valid`=1; `result_index`=count; clear both flags; count++.
  - If count+1 == `n`, go to DONE; otherwise go to RUN. The core keeps running, with no re-clear between measurements.
  - A valid arriving during EMIT is captured for the next pair.
- **DONE**
  - `done`=1 for one cycle; `lockin_enable`=0; go to IDLE.
- **Timer**
  - Reset on entering ARM and on entering RUN.
  - Counts every cycle in ARM/RUN; timeout fires when timer == `cfg_timeout`-1 and `cfg_timeout`≠0.
- **abort**
  - Highest priority. The next state is IDLE and `lockin_enable` drops on the following edge.
  - Captured data is discarded; no `done` or `result_valid`; error flags are unchanged.
- `start` while busy is ignored. Config inputs changing mid-run have no effect.

## Timing
- **Reset values:** `state`=IDLE; `lockin_reset_n`=1; `lockin_enable`=0; `busy`=0; `done`=0; `result_valid`=0; error flags=0; `result_fase`/`result_cuad`/`result_index`/`ptos_x_ciclo`/`frames_integracion`=0.
- All outputs are registered.
- `start` sampled at edge k: `busy`=1 and `lockin_reset_n`=0 from edge k+1; `lockin_enable`=1 from edge k+1+CLEAR_CYCLES.
- `lockin_ready` sampled at edge j: RUN from j+1. Valids are sampled only in RUN and EMIT.
- Second of the pair sampled at edge m: `result_valid`=1 during m+1..m+2, i.e. one cycle.
  - Pairs of the same cycle (both valids at edge m) behave identically.
- After the last EMIT: `done` asserted for one cycle and `busy` still 1; `busy`=0 the cycle after.
- Asynchronous reset mid-run: all outputs return to reset values immediately, including `lockin_enable`=0.

## Test plan
- **Single run:** ptos=100, frames=4, n=1, timeout=0; ready 10 cycles after enable; fase=0x10, then cuad=0x20 three cycles later. Required: `lockin_reset_n` low exactly 4 cycles; one `result_valid` with 0x10/0x20, index 0; `done` pulse; `busy` falls.
- **Multi-run, same-cycle pairs:** n=3; pairs arrive with both valids together; quad before phase for pair 2. Required: indices 0,1,2 in order, correct values, one `done`.
- **Timeout:** timeout=50, `lockin_ready` never asserted. Required: IDLE after 50 ARM cycles; `error_timeout`=1; no `done`. A following `start` clears the flag.
- **Overrun:** two `fase_in_valid` (0xA, then 0xB) before `cuad_in_valid`. Required: record carries 0xB; `error_overrun`=1.
- **Abort and reset:** `abort` during RUN with `have_f` set → IDLE next cycle, `lockin_enable`=0, no result. Async `reset_n` in ARM → all outputs at reset values. `start` while busy is ignored.
- **n=0:** run with `cfg_n_mediciones`=0 behaves exactly as n=1.

Source files
------------

// File: rtl/control_adquisicion_lockin.sv
// Run sequencer for the segmented lock-in core: clears and enables the core, then pairs
// phase/quadrature results into numbered records for a programmed number of measurements.
module control_adquisicion_lockin #(
  parameter int unsigned CLEAR_CYCLES = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      cfg_ptos_x_ciclo,
  input  logic [15:0]      cfg_frames_integracion,
  input  logic [CNT_W-1:0] cfg_n_mediciones,
  input  logic [31:0]      cfg_timeout,
  output logic             lockin_reset_n,
  output logic             lockin_enable,
  output logic [15:0]      ptos_x_ciclo,
  output logic [15:0]      frames_integracion,
  input  logic             lockin_ready,
  input  logic [63:0]      fase_in,
  input  logic             fase_in_valid,
  input  logic [63:0]      cuad_in,
  input  logic             cuad_in_valid,
  output logic [63:0]      result_fase,
  output logic [63:0]      result_cuad,
  output logic             result_valid,
  output logic [CNT_W-1:0] result_index,
  output logic             busy,
  output logic             done,
  output logic             error_timeout,
  output logic             error_overrun,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StArm   = 3'd2,
    StRun   = 3'd3,
    StEmit  = 3'd4,
    StDone  = 3'd5
  } state_e;

  localparam int unsigned ClrW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [ClrW-1:0] ClrLast = ClrW'(CLEAR_CYCLES - 1);

  state_e           state_q, state_d;
  logic [ClrW-1:0]  clr_cnt_q;
  logic [31:0]      timer_q, timeout_q;
  logic [CNT_W-1:0] n_q, count_q;
  logic [63:0]      fase_q, cuad_q;
  logic             have_f_q, have_c_q;

  logic pair_full, tmo_hit, tmo_fire, last_meas, sample;

  assign state = state_q;

  always_comb begin
    sample    = (state_q == StRun) || (state_q == StEmit);
    pair_full = (have_f_q | fase_in_valid) & (have_c_q | cuad_in_valid);
    tmo_hit   = (timeout_q != 32'd0) && (timer_q == timeout_q - 32'd1);
    last_meas = (count_q + CNT_W'(1)) == n_q;
    tmo_fire  = !abort && tmo_hit &&
                (((state_q == StArm) && !lockin_ready) || ((state_q == StRun) && !pair_full));

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StClear;
      StClear: if (clr_cnt_q == ClrLast) state_d = StArm;
      StArm: begin
        if (lockin_ready) state_d = StRun;
        else if (tmo_hit) state_d = StIdle;
      end
      StRun: begin
        if (pair_full) state_d = StEmit;
        else if (tmo_hit) state_d = StIdle;
      end
      StEmit:  state_d = last_meas ? StDone : StRun;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= StIdle;
      clr_cnt_q          <= '0;
      timer_q            <= '0;
      timeout_q          <= '0;
      n_q                <= '0;
      count_q            <= '0;
      fase_q             <= '0;
      cuad_q             <= '0;
      have_f_q           <= 1'b0;
      have_c_q           <= 1'b0;
      lockin_reset_n     <= 1'b1;
      lockin_enable      <= 1'b0;
      ptos_x_ciclo       <= '0;
      frames_integracion <= '0;
      result_fase        <= '0;
      result_cuad        <= '0;
      result_valid       <= 1'b0;
      result_index       <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      error_timeout      <= 1'b0;
      error_overrun      <= 1'b0;
    end else begin
      state_q        <= state_d;
      // Outputs follow the next state so they change on the same edge as the state.
      busy           <= (state_d != StIdle);
      lockin_reset_n <= (state_d != StClear);
      lockin_enable  <= (state_d == StArm) || (state_d == StRun) || (state_d == StEmit);
      result_valid   <= (state_d == StEmit);
      done           <= (state_d == StDone);
      timer_q        <= (state_d != state_q) ? 32'd0 : timer_q + 32'd1;

      if ((state_q == StIdle) && (state_d == StClear)) begin
        ptos_x_ciclo       <= cfg_ptos_x_ciclo;
        frames_integracion <= cfg_frames_integracion;
        timeout_q          <= cfg_timeout;
        n_q                <= (cfg_n_mediciones == '0) ? CNT_W'(1) : cfg_n_mediciones;
        count_q            <= '0;
        clr_cnt_q          <= '0;
        error_timeout      <= 1'b0;
        error_overrun      <= 1'b0;
      end

      if (state_q == StClear) clr_cnt_q <= clr_cnt_q + ClrW'(1);
      if (tmo_fire) error_timeout <= 1'b1;

      if (!abort && sample) begin
        if ((state_q == StRun) && (state_d == StEmit)) begin
          result_fase  <= fase_in_valid ? fase_in : fase_q;
          result_cuad  <= cuad_in_valid ? cuad_in : cuad_q;
          result_index <= count_q;
          have_f_q     <= 1'b0;
          have_c_q     <= 1'b0;
        end else begin
          // Valids seen during EMIT land here and start the next pair.
          if (fase_in_valid) begin
            fase_q   <= fase_in;
            have_f_q <= 1'b1;
          end
          if (cuad_in_valid) begin
            cuad_q   <= cuad_in;
            have_c_q <= 1'b1;
          end
        end
        if ((fase_in_valid && have_f_q) || (cuad_in_valid && have_c_q)) error_overrun <= 1'b1;
      end

      if (state_q == StEmit) count_q <= count_q + CNT_W'(1);

      if (state_d == StIdle) begin
        have_f_q <= 1'b0;
        have_c_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_control_adquisicion_lockin.sv
// Bench for control_adquisicion_lockin: table-driven runs with a result scoreboard plus
// hand-written timeout, overrun, abort and asynchronous-reset sequences.
module tb_control_adquisicion_lockin;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StClear = 3'd1;
  localparam logic [2:0] StArm   = 3'd2;
  localparam logic [2:0] StRun   = 3'd3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cfg_ptos_x_ciclo = '0;
  logic [15:0] cfg_frames_integracion = '0;
  logic [15:0] cfg_n_mediciones = '0;
  logic [31:0] cfg_timeout = '0;
  logic        lockin_reset_n, lockin_enable;
  logic [15:0] ptos_x_ciclo, frames_integracion;
  logic        lockin_ready = 1'b0;
  logic [63:0] fase_in = '0;
  logic        fase_in_valid = 1'b0;
  logic [63:0] cuad_in = '0;
  logic        cuad_in_valid = 1'b0;
  logic [63:0] result_fase, result_cuad;
  logic        result_valid;
  logic [15:0] result_index;
  logic        busy, done, error_timeout, error_overrun;
  logic [2:0]  state;

  always #5 clock = ~clock;

  control_adquisicion_lockin #(
    .CLEAR_CYCLES(4),
    .CNT_W       (16)
  ) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .start                 (start),
    .abort                 (abort),
    .cfg_ptos_x_ciclo      (cfg_ptos_x_ciclo),
    .cfg_frames_integracion(cfg_frames_integracion),
    .cfg_n_mediciones      (cfg_n_mediciones),
    .cfg_timeout           (cfg_timeout),
    .lockin_reset_n        (lockin_reset_n),
    .lockin_enable         (lockin_enable),
    .ptos_x_ciclo          (ptos_x_ciclo),
    .frames_integracion    (frames_integracion),
    .lockin_ready          (lockin_ready),
    .fase_in               (fase_in),
    .fase_in_valid         (fase_in_valid),
    .cuad_in               (cuad_in),
    .cuad_in_valid         (cuad_in_valid),
    .result_fase           (result_fase),
    .result_cuad           (result_cuad),
    .result_valid          (result_valid),
    .result_index          (result_index),
    .busy                  (busy),
    .done                  (done),
    .error_timeout         (error_timeout),
    .error_overrun         (error_overrun),
    .state                 (state)
  );

  typedef struct {
    logic [63:0] f;
    logic [63:0] c;
    logic [15:0] idx;
  } rec_t;

  typedef struct {
    logic [15:0] n_cfg;
    int          n_eff;
    logic [31:0] to;
    logic [7:0]  modes;  // 2 bits per pair: 0 fase then cuad +3, 1 same cycle, 2 cuad first
    logic [63:0] base;
  } run_t;

  rec_t exp_q[$];
  rec_t mon_e;
  run_t runs[4];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int res_cnt = 0;
  logic rv_prev = 1'b0;
  int cnt, d0, rc0;
  logic [63:0] fv, cv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (done === 1'b1) done_cnt++;
    if (result_valid === 1'b1) begin
      res_cnt++;
      check("result_valid_one_cycle", {63'd0, rv_prev}, 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_result", {63'd0, result_valid}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_fase", result_fase, mon_e.f);
        check("result_cuad", result_cuad, mon_e.c);
        check("result_index", {48'd0, result_index}, {48'd0, mon_e.idx});
      end
    end
    rv_prev = result_valid;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_exp(input logic [63:0] f, input logic [63:0] c, input int idx);
    rec_t r;
    r.f = f;
    r.c = c;
    r.idx = 16'(idx);
    exp_q.push_back(r);
  endtask

  task automatic start_run(input logic [15:0] p, input logic [15:0] fr, input logic [15:0] n,
                           input logic [31:0] to);
    cfg_ptos_x_ciclo = p;
    cfg_frames_integracion = fr;
    cfg_n_mediciones = n;
    cfg_timeout = to;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int budget, input string name);
    int c;
    c = 0;
    while (state !== tgt && c < budget) begin
      tick();
      c++;
    end
    check(name, {61'd0, state}, {61'd0, tgt});
  endtask

  task automatic send_pair(input int mode, input logic [63:0] f, input logic [63:0] c);
    case (mode)
      1: begin
        fase_in = f; cuad_in = c; fase_in_valid = 1'b1; cuad_in_valid = 1'b1;
        tick();
        fase_in_valid = 1'b0; cuad_in_valid = 1'b0;
      end
      2: begin
        cuad_in = c; cuad_in_valid = 1'b1;
        tick();
        cuad_in_valid = 1'b0; fase_in = f; fase_in_valid = 1'b1;
        tick();
        fase_in_valid = 1'b0;
      end
      default: begin
        fase_in = f; fase_in_valid = 1'b1;
        tick();
        fase_in_valid = 1'b0;
        tick(2);
        cuad_in = c; cuad_in_valid = 1'b1;
        tick();
        cuad_in_valid = 1'b0;
      end
    endcase
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (done !== 1'b1 && c < budget) begin
      tick();
      c++;
    end
    check("done_pulse", {63'd0, done}, 64'd1);
    check("busy_during_done", {63'd0, busy}, 64'd1);
    check("enable_off_in_done", {63'd0, lockin_enable}, 64'd0);
    tick();
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("busy_after_done", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    runs[0] = '{16'd3, 3, 32'd0,    {2'd0, 2'd1, 2'd2, 2'd1}, 64'h100};
    runs[1] = '{16'd0, 1, 32'd0,    8'd0,                     64'h200};
    runs[2] = '{16'd2, 2, 32'd1000, {2'd0, 2'd0, 2'd2, 2'd0}, 64'h300};
    runs[3] = '{16'd4, 4, 32'd0,    {2'd1, 2'd1, 2'd1, 2'd1}, 64'h400};

    tick(2);
    check("rst_state", {61'd0, state}, {61'd0, StIdle});
    check("rst_lockin_reset_n", {63'd0, lockin_reset_n}, 64'd1);
    check("rst_enable", {63'd0, lockin_enable}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_outputs", {ptos_x_ciclo, frames_integracion, result_index, 16'd0}, 64'd0);
    reset_n = 1'b1;
    tick(2);

    // Single run: ptos=100, frames=4, n=1, no timeout.
    start_run(16'd100, 16'd4, 16'd1, 32'd0);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("clear_state", {61'd0, state}, {61'd0, StClear});
    check("cfg_ptos_in_clear", {48'd0, ptos_x_ciclo}, 64'd100);
    check("cfg_frames_in_clear", {48'd0, frames_integracion}, 64'd4);
    check("enable_off_in_clear", {63'd0, lockin_enable}, 64'd0);
    cnt = 0;
    while (lockin_reset_n === 1'b0 && cnt < 20) begin
      cnt++;
      tick();
    end
    check("clear_low_cycles", cnt, 4);
    check("enable_after_clear", {63'd0, lockin_enable}, 64'd1);
    check("arm_after_clear", {61'd0, state}, {61'd0, StArm});
    tick(10);
    lockin_ready = 1'b1;
    wait_state(StRun, 5, "ready_to_run");
    rc0 = res_cnt;
    push_exp(64'h10, 64'h20, 0);
    send_pair(0, 64'h10, 64'h20);
    wait_done(20);
    check("single_run_results", res_cnt - rc0, 1);
    lockin_ready = 1'b0;
    tick(2);

    for (int r = 0; r < 4; r++) begin
      d0 = done_cnt;
      rc0 = res_cnt;
      start_run(16'(10 + r), 16'd2, runs[r].n_cfg, runs[r].to);
      wait_state(StArm, 20, "reach_arm");
      lockin_ready = 1'b1;
      wait_state(StRun, 10, "reach_run");
      for (int i = 0; i < runs[r].n_eff; i++) begin
        fv = runs[r].base + 64'(i);
        cv = ~(runs[r].base + 64'(i * 3));
        push_exp(fv, cv, i);
        send_pair(int'(runs[r].modes[2*i +: 2]), fv, cv);
        if (i != runs[r].n_eff - 1) wait_state(StRun, 10, "back_to_run");
      end
      wait_done(20);
      lockin_ready = 1'b0;
      check("results_per_run", res_cnt - rc0, runs[r].n_eff);
      check("done_per_run", done_cnt - d0, 1);
      check("no_errors_run", {62'd0, error_timeout, error_overrun}, 64'd0);
      check("queue_drained", exp_q.size(), 0);
      tick(2);
    end

    // Timeout in ARM with a start pulse ignored while busy.
    d0 = done_cnt;
    start_run(16'd50, 16'd8, 16'd1, 32'd50);
    wait_state(StArm, 20, "arm_for_timeout");
    cnt = 0;
    while (state === StArm && cnt < 200) begin
      if (cnt == 5) begin
        cfg_ptos_x_ciclo = 16'd7;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      cnt++;
    end
    start = 1'b0;
    check("arm_cycles_to_timeout", cnt, 50);
    check("error_timeout_set", {63'd0, error_timeout}, 64'd1);
    check("idle_after_timeout", {61'd0, state}, {61'd0, StIdle});
    check("start_while_busy_ignored", {48'd0, ptos_x_ciclo}, 64'd50);
    check("no_done_on_timeout", done_cnt - d0, 0);

    // Overrun: two phase valids before the quadrature one.
    start_run(16'd1, 16'd1, 16'd1, 32'd0);
    check("start_clears_timeout", {63'd0, error_timeout}, 64'd0);
    wait_state(StArm, 20, "arm_overrun");
    lockin_ready = 1'b1;
    wait_state(StRun, 10, "run_overrun");
    push_exp(64'hB, 64'hC0, 0);
    fase_in = 64'hA; fase_in_valid = 1'b1;
    tick();
    fase_in_valid = 1'b0;
    tick();
    fase_in = 64'hB; fase_in_valid = 1'b1;
    tick();
    fase_in_valid = 1'b0;
    tick();
    cuad_in = 64'hC0; cuad_in_valid = 1'b1;
    tick();
    cuad_in_valid = 1'b0;
    wait_done(20);
    check("error_overrun_set", {63'd0, error_overrun}, 64'd1);

    // Abort in RUN with a captured phase value.
    d0 = done_cnt;
    rc0 = res_cnt;
    start_run(16'd2, 16'd2, 16'd2, 32'd0);
    check("start_clears_overrun", {63'd0, error_overrun}, 64'd0);
    wait_state(StRun, 20, "run_abort");
    fase_in = 64'h55; fase_in_valid = 1'b1;
    tick();
    fase_in_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", {61'd0, state}, {61'd0, StIdle});
    check("abort_enable_off", {63'd0, lockin_enable}, 64'd0);
    check("abort_busy_off", {63'd0, busy}, 64'd0);
    tick(3);
    check("abort_no_result", res_cnt - rc0, 0);
    check("abort_no_done", done_cnt - d0, 0);

    // The aborted phase value must not pair with the next quadrature.
    start_run(16'd3, 16'd3, 16'd1, 32'd0);
    wait_state(StRun, 20, "run_after_abort");
    push_exp(64'h77, 64'h66, 0);
    send_pair(2, 64'h77, 64'h66);
    wait_done(20);
    lockin_ready = 1'b0;
    tick(2);

    // Asynchronous reset while in ARM.
    start_run(16'd9, 16'd9, 16'd1, 32'd0);
    wait_state(StArm, 20, "arm_before_reset");
    #2 reset_n = 1'b0;
    #1;
    check("areset_state", {61'd0, state}, {61'd0, StIdle});
    check("areset_enable", {63'd0, lockin_enable}, 64'd0);
    check("areset_lockin_reset_n", {63'd0, lockin_reset_n}, 64'd1);
    check("areset_busy", {63'd0, busy}, 64'd0);
    check("areset_cfg", {32'd0, ptos_x_ciclo, frames_integracion}, 64'd0);
    check("areset_result_fase", result_fase, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick(2);
    check("queue_empty_end", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
